// File: rtl/ub_pkg.sv
// Shared constants and types for the unified-buffer controller slice.
package ub_pkg;

  localparam int DATA_W = 16;              // lane width
  localparam int LANES  = 32;              // lanes per buffer row
  localparam int ADDR_W = 12;              // 4096 rows
  localparam int LEN_W  = 13;              // burst length 0..4096
  localparam int ROW_W  = LANES * DATA_W;  // flattened row width

  typedef logic [LANES-1:0][DATA_W-1:0] ub_row_t;
  typedef logic [ADDR_W-1:0]            ub_addr_t;
  typedef logic [LEN_W-1:0]             ub_len_t;

  // Read sequencer: idle, issuing rows, waiting for the last row's data.
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_DRAIN
  } rd_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;

  // Grant: a lone requester always wins; on contention the pointer holder wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // Pointer passes to the other requester once its current holder has been served.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else if (gnt_o[ptr_q]) begin
      ptr_q <= ~ptr_q;
    end
  end

endmodule

// File: rtl/ub_controller.sv
// Unified-buffer controller: burst read sequencer toward the matrix unit and
// round-robin arbitration of the single buffer write port.
module ub_controller
  import ub_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rd_cmd_valid_i,
  output logic                rd_cmd_ready_o,
  input  logic [ADDR_W-1:0]   rd_base_i,
  input  logic [LEN_W-1:0]    rd_len_i,
  input  logic                mmu_ready_i,
  output logic                rd_data_valid_o,
  output logic                rd_done_o,
  output logic                ub_read_o,
  output logic [ADDR_W-1:0]   ub_addr_rd_o,
  input  logic [1:0]          wr_valid_i,
  output logic [1:0]          wr_ready_o,
  input  logic [2*ADDR_W-1:0] wr_addr_i,
  input  logic [2*ROW_W-1:0]  wr_data_i,
  output logic                ub_write_o,
  output logic [ADDR_W-1:0]   ub_addr_wr_o,
  output logic [ROW_W-1:0]    ub_data_o
);

  // ---------------- read sequencer ----------------
  rd_state_e state_q, state_d;
  ub_addr_t  next_addr_q, next_addr_d;  // address of the next row to issue
  ub_len_t   remain_q, remain_d;        // rows not yet issued
  logic      read_q, read_d;
  ub_addr_t  addr_rd_q, addr_rd_d;
  logic      valid_q;
  logic      zero_done_q, zero_done_d;  // done pulse for a zero-length command
  logic      issue;

  // Next-state and next-output logic; a row is issued whenever the matrix unit is ready.
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    remain_d    = remain_q;
    read_d      = 1'b0;
    addr_rd_d   = addr_rd_q;
    zero_done_d = 1'b0;
    issue       = 1'b0;

    case (state_q)
      RD_IDLE: begin
        if (rd_cmd_valid_i) begin
          if (rd_len_i == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d     = RD_ISSUE;
            next_addr_d = rd_base_i;
            remain_d    = rd_len_i;
            issue       = mmu_ready_i;
          end
        end
      end
      RD_ISSUE: begin
        // The last row is on ub_read_o this cycle; its data lands during DRAIN.
        if (remain_q == '0) state_d = RD_DRAIN;
        else                issue   = mmu_ready_i;
      end
      RD_DRAIN: state_d = RD_IDLE;
      default:  state_d = RD_IDLE;
    endcase

    if (issue) begin
      read_d      = 1'b1;
      addr_rd_d   = next_addr_d;
      next_addr_d = next_addr_d + ub_addr_t'(1);  // wraps 4095 -> 0
      remain_d    = remain_d - ub_len_t'(1);
    end
  end

  // Read-side registers; data valid follows the issued read by one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RD_IDLE;
      next_addr_q <= '0;
      remain_q    <= '0;
      read_q      <= 1'b0;
      addr_rd_q   <= '0;
      valid_q     <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      remain_q    <= remain_d;
      read_q      <= read_d;
      addr_rd_q   <= addr_rd_d;
      valid_q     <= read_q;
      zero_done_q <= zero_done_d;
    end
  end

  assign rd_cmd_ready_o  = (state_q == RD_IDLE);
  assign ub_read_o       = read_q;
  assign ub_addr_rd_o    = addr_rd_q;
  assign rd_data_valid_o = valid_q;
  assign rd_done_o       = (state_q == RD_DRAIN) || zero_done_q;

  // ---------------- write arbitration ----------------
  ub_addr_t wa_sel;
  ub_row_t  wd_sel;
  logic     write_q;
  ub_addr_t addr_wr_q;
  ub_row_t  data_q;

  rr_arbiter2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (wr_valid_i),
    .gnt_o (wr_ready_o)
  );

  // Select the granted requester's address and row.
  always_comb begin
    wa_sel = wr_addr_i[0 +: ADDR_W];
    wd_sel = wr_data_i[0 +: ROW_W];
    if (wr_ready_o[1]) begin
      wa_sel = wr_addr_i[ADDR_W +: ADDR_W];
      wd_sel = wr_data_i[ROW_W +: ROW_W];
    end
  end

  // Register the granted write; address and data hold between writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      write_q   <= 1'b0;
      addr_wr_q <= '0;
      data_q    <= '0;
    end else begin
      write_q <= |wr_ready_o;
      if (|wr_ready_o) begin
        addr_wr_q <= wa_sel;
        data_q    <= wd_sel;
      end
    end
  end

  assign ub_write_o   = write_q;
  assign ub_addr_wr_o = addr_wr_q;
  assign ub_data_o    = data_q;

endmodule

// File: doc/ub_controller.md
Name: ub_controller

Overview:
- Sequences the single-read/single-write unified buffer: turns burst read commands into one row-read per cycle toward the matrix unit, and arbitrates the buffer write port between two requesters.
- Write requesters: host loader (req 0) and accumulator writeback (req 1).
- Sits between the top-level control FSM / host DMA / accumulators and unified_buffer; drives read_i, write_i, addresses and write data.

Parameters:
- DATA_W, 16, lane width.
- LANES, 32, row width in lanes.
- ADDR_W, 12, buffer row address width (4096 rows).
- LEN_W, 13, burst length width (0..4096 rows).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- rd_cmd_valid_i  in  1  burst read command valid.
- rd_cmd_ready_o  out  1  controller idle, command accepted when valid&ready.
- rd_base_i  in  ADDR_W  first row address.
- rd_len_i  in  LEN_W  rows to read.
- mmu_ready_i  in  1  matrix unit can take a row next cycle; low stalls issue.
- rd_data_valid_o  out  1  ub data_o holds a requested row this cycle.
- rd_done_o  out  1  one-cycle pulse, burst finished.
- ub_read_o  out  1  to unified_buffer read_i.
- ub_addr_rd_o  out  ADDR_W  to unified_buffer addr_rd.
- wr_valid_i  in  2  per-requester write valid.
- wr_ready_o  out  2  per-requester grant (combinational).
- wr_addr_i  in  2 x ADDR_W  per-requester row address.
- wr_data_i  in  2 x LANES x DATA_W  per-requester row data.
- ub_write_o  out  1  to unified_buffer write_i.
- ub_addr_wr_o  out  ADDR_W  to unified_buffer addr_wr.
- ub_data_o  out  LANES x DATA_W  to unified_buffer data_i.

Behaviour:
- Clock clk_i; reset rst_i synchronous, active-high. Reset values: all outputs 0 except rd_cmd_ready_o=1; rr pointer=0; read FSM=IDLE; counters 0.
- Read FSM states IDLE, ISSUE, DRAIN.
  - IDLE: rd_cmd_ready_o=1. On accept with len>0, latch base/len, go ISSUE. On accept with len=0, no reads; rd_done_o pulses next cycle; stay IDLE.
  - ISSUE: rd_cmd_ready_o=0. Each cycle mmu_ready_i=1: ub_read_o=1, ub_addr_rd_o=current address; address+1, remaining-1. mmu_ready_i=0: ub_read_o=0, address held.
  - ISSUE -> DRAIN after issuing the last row.
  - DRAIN: one cycle; rd_done_o=1 together with the last rd_data_valid_o; then IDLE.
- ub_read_o and ub_addr_rd_o are registered outputs. First read is issued the cycle after command accept.
- Read latency 1: rd_data_valid_o = ub_read_o delayed one cycle, independent of later mmu_ready_i.
- Address wrap: 4095+1 -> 0; no error.
- Write arbiter (round-robin, 2 requesters):
  - Single valid: grant it.
  - Both valid: grant pointer holder.
  - Pointer moves to the other requester after any grant to its current holder; otherwise unchanged.
  - wr_ready_o is one-hot or zero.
- Write output registered: the cycle after a grant, ub_write_o=1 with the granted addr/data. Otherwise ub_write_o=0, addr/data hold last value.
- Same-row read and write in one cycle: read returns pre-write data (buffer read-before-write); no forwarding, no hazard stall.
- Read and write paths are independent; both may be active every cycle.
- rst_i mid-burst: burst aborted, no rd_done_o, a pending rd_data_valid_o is cleared, pending write dropped; all outputs at reset values after the edge.

Decomposition:
- Package ub_pkg: DATA_W, LANES, ADDR_W, LEN_W; typedefs ub_row_t (LANES x DATA_W array), ub_addr_t; read FSM state enum.
- Sub-module rr_arbiter2: 2-way round-robin, combinational grant plus registered pointer; reusable for weight-FIFO sharing.

Test Plan:
- Base 10, len 4, mmu_ready_i=1 -> ub_addr_rd_o 10,11,12,13 on four consecutive cycles from accept+1. rd_data_valid_o high cycles accept+2..+5. rd_done_o at accept+5.
- Base 4094, len 3, mmu_ready_i low on cycle 2 of the burst -> addresses 4094, (stall), 4095, 0. Three valids; done aligned with last valid.
- len 0 command -> no ub_read_o; rd_done_o pulse one cycle after accept; rd_cmd_ready_o stays 1.
- Both write requesters valid for 4 cycles (addr 5 and 9) -> grants 0,1,0,1. ub_write_o high 4 cycles, addresses 5,9,5,9 one cycle later.
- Write row 7 = all 0x0003 while reading row 7 (previously 0x0001) in the same cycle -> read returns 0x0001; a re-read next cycle returns 0x0003.
- rst_i asserted on burst row 2 of 6 -> next cycle ub_read_o=0, rd_data_valid_o=0, rd_cmd_ready_o=1, no rd_done_o; a new command then runs normally.
